// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the round-robin register-bank arbiter:
// FSM state encoding, default geometry and the winner-selection function.
package reg_bank_pkg;

  localparam int DEFAULT_NREQ  = 2;
  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 4;
  localparam int MAX_NREQ      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_e;

  // First set request bit found scanning ptr, ptr+1, ... modulo nreq.
  function automatic logic [2:0] rr_winner(input logic [MAX_NREQ-1:0] req,
                                           input logic [2:0]          ptr,
                                           input int                  nreq);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      idx = (int'(ptr) + k) % nreq;
      if (k < nreq && !found && req[3'(idx)]) begin
        win   = 3'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester/reader bus of the register-bank arbiter: packed per-requester
// write channels, one-hot grant/ack, and a combinational read port.
interface reg_bank_arbiter_if #(
  parameter int NREQ  = reg_bank_pkg::DEFAULT_NREQ,
  parameter int WIDTH = reg_bank_pkg::DEFAULT_WIDTH,
  parameter int DEPTH = reg_bank_pkg::DEFAULT_DEPTH
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    wr_addr;
  logic [NREQ*WIDTH-1:0] wr_data;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic [AW-1:0]         rd_addr;
  logic [WIDTH-1:0]      rd_data;

  modport master (
    output req, wr_addr, wr_data, rd_addr,
    input  gnt, ack, busy, rd_data
  );

  modport slave (
    input  req, wr_addr, wr_data, rd_addr,
    output gnt, ack, busy, rd_data
  );

endinterface

// File: rtl/reg_bank.sv
// DEPTH x WIDTH register storage: one write port, one combinational read
// port, asynchronous clear to zero. Out-of-range addresses write nothing, read 0.
module reg_bank #(
  parameter int WIDTH = reg_bank_pkg::DEFAULT_WIDTH,
  parameter int DEPTH = reg_bank_pkg::DEFAULT_DEPTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [DEPTH*WIDTH-1:0] flat;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_d;

    always_comb begin
      reg_d = reg_q;
      if (we && waddr == AW'(gi)) begin
        reg_d = wdata;
      end
    end

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign flat[gi*WIDTH +: WIDTH] = reg_q;
  end

  // Address match per entry, so addresses beyond DEPTH fall through to zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) begin
        rdata = flat[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter serialising requester writes into a shared register
// bank through an IDLE -> GRANT -> ACK handshake, one write per transaction.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic            clk,
  input  logic            clr,
  reg_bank_arbiter_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [PW-1:0]    pick;

  assign pick = PW'(rr_winner(MAX_NREQ'(bus.req), 3'(ptr_q), NREQ));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    addr_d  = addr_q;
    data_d  = data_q;
    gnt_d   = '0;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        // Capture the winner's channel so it may change once gnt is seen.
        if (|bus.req) begin
          win_d   = pick;
          addr_d  = bus.wr_addr[int'(pick)*AW +: AW];
          data_d  = bus.wr_data[int'(pick)*WIDTH +: WIDTH];
          gnt_d   = NREQ'(1) << pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        ack_d   = NREQ'(1) << win_q;
        state_d = ACK;
      end
      ACK: begin
        ptr_d   = (int'(win_q) == NREQ - 1) ? '0 : win_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_q;
  assign bus.busy = (state_q != IDLE);

  // The bank commits on the edge leaving GRANT, so a read of the same
  // address shows the old value in GRANT and the new one from ACK onward.
  reg_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk   (clk),
    .clr   (clr),
    .we    (state_q == GRANT),
    .waddr (addr_q),
    .wdata (data_q),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data)
  );

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares a small bank of 4-bit registers between several write requesters using round-robin arbitration and a req/gnt/ack handshake.
- Provides one combinational read port into the bank.
- Sits between producer blocks and register storage, serialising writes so that at most one write commits per transaction.

Parameters:
- NREQ, 2: number of write requesters (2..8).
- WIDTH, 4: register data width in bits.
- DEPTH, 4: number of registers in the bank; AW = $clog2(DEPTH), derived localparam.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester write request, level.
- wr_addr  in  NREQ*AW  packed target addresses; requester i occupies bits [i*AW +: AW].
- wr_data  in  NREQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot grant, registered.
- ack  out  NREQ  one-hot write-complete pulse, registered.
- busy  out  1  high whenever state is not IDLE.
- rd_addr  in  AW  read address.
- rd_data  out  WIDTH  combinational read of bank[rd_addr].

Behaviour:
- Reset (clr=1, asynchronous): all bank registers 0; gnt=0, ack=0, busy=0; state=IDLE; round-robin pointer ptr=0.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If req is nonzero at the rising edge, pick winner w = the first set req bit searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - Capture addr/data of w into internal registers; set gnt[w]=1; go to GRANT.
  - If req is zero, stay in IDLE.
- GRANT (exactly 1 cycle):
  - At the edge, write bank[addr_q] <= data_q; gnt=0; ack[w]=1; go to ACK.
- ACK (exactly 1 cycle):
  - At the edge, ack=0; ptr = (w+1) mod NREQ; go to IDLE.
- Timing: latency from req sampled to ack high is 2 edges. Throughput is one write per 3 cycles.
- Handshake: a requester holds req, addr and data stable until it sees gnt. Once gnt is seen, inputs may change, because the write uses the captured copy. The requester must deassert req in the ACK cycle; req still high in IDLE counts as a new request.
- req dropped during GRANT: the write still completes and ack still pulses.
- Single active requester: granted regardless of ptr.
- All requesters active: strict rotation 0,1,...,NREQ-1,0; no requester is granted twice while another waits.
- Read/write collision: rd_addr equal to addr_q during GRANT returns the old value; the new value is visible from the ACK cycle onward.
- Out-of-range address (DEPTH not a power of two, addr >= DEPTH): the write is dropped, but gnt/ack still cycle normally.
- Out-of-range rd_addr returns 0.
- clr mid-operation (GRANT or ACK): return immediately to IDLE; the bank is cleared; gnt/ack drop to 0 without completing; the in-flight write is lost.
- gnt and ack are never high in the same cycle; at most one bit of each is set.

Decomposition:
- Package reg_bank_pkg: state enum (IDLE, GRANT, ACK), default WIDTH/DEPTH constants, and a function computing the round-robin winner from (req, ptr).
- Sub-module reg_bank: DEPTH x WIDTH storage with asynchronous clr to 0, one write port (we, waddr, wdata) and a combinational read port.
- The arbiter holds the FSM, the ptr register and the capture registers.

Test Plan:
- Reset: assert clr for 20 ns during busy traffic -> gnt=0, ack=0, busy=0, and rd_data=0 for rd_addr 0..3.
- Single write: req=2'b01, wr_addr0=2, wr_data0=4'h5 -> gnt=01 one cycle later, then ack=01 one cycle after that; rd_addr=2 returns 4'h5 from the ACK cycle onward.
- Contention: req=2'b11 held continuously, each requester writing a distinct address (r0: addr 1 <- 4'hA; r1: addr 3 <- 4'hC) -> grants alternate 01,10,01,10 starting with 01; bank[1]=A, bank[3]=C.
- Fairness: after r1 wins, assert req=2'b11 -> r0 is granted next (ptr wrapped), not r1.
- Collision: during GRANT writing 4'h9 to addr 0, with rd_addr=0 and bank[0]=4'h3 -> rd_data=4'h3 in the GRANT cycle and 4'h9 in the ACK cycle.
- Abort: pulse clr while in GRANT of a write of 4'hF to addr 2 -> ack never pulses; bank[2]=0; state returns to IDLE; the next req is served normally.
